// File: rtl/vector_pkg.sv
// Display-list record format shared by the list writer and the list reader.
package vector_pkg;

    localparam int VEC_OUT_W = 8;

    typedef enum logic [1:0] {
        DEC_SKIP = 2'b00,
        DEC_MOVE = 2'b01,
        DEC_LINE = 2'b10,
        DEC_END  = 2'b11
    } vec_dec_e;

    typedef struct packed {
        logic [VEC_OUT_W-1:0] x;
        logic [VEC_OUT_W-1:0] y;
        logic                 line;
        logic                 pos;
    } vec_rec_t;

    localparam vec_rec_t REC_END = '{x: '0, y: '0, line: 1'b1, pos: 1'b1};

    function automatic vec_dec_e vec_decode(input logic [1:0] line_pos);
        return vec_dec_e'(line_pos);
    endfunction

endpackage

// File: rtl/vector_list_reader.sv
// Walks the vector display list in RAM from address 0 and hands each line record
// to the line drawer over valid/ready; pulses frame_done on the terminator.
module vector_list_reader
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH  = 8,
    parameter int ADR_WIDTH  = 16,
    parameter int DATAWIDTH  = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 draw_frame,
    output logic                 frame_done,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic [OUT_WIDTH-1:0] x0,
    output logic [OUT_WIDTH-1:0] y0,
    output logic [OUT_WIDTH-1:0] x1,
    output logic [OUT_WIDTH-1:0] y1,
    output logic                 line_valid,
    input  logic                 line_ready,
    output logic                 overrun,
    output logic [2:0]           state_debug
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_DECODE  = 3'd3,
        S_ISSUE   = 3'd4,
        S_REARM   = 3'd5
    } state_e;

    localparam logic [ADR_WIDTH-1:0] ADR_LAST = '1;
    localparam logic [ADR_WIDTH-1:0] ADR_ONE  = {{(ADR_WIDTH-1){1'b0}}, 1'b1};

    state_e               state, state_nxt;
    logic [1:0]           lat_cnt;
    logic [DATAWIDTH-1:0] rec;
    logic [OUT_WIDTH-1:0] cx, cy;
    logic [OUT_WIDTH-1:0] rec_x, rec_y;
    logic                 at_last;
    vec_dec_e             dec;

    assign rec_x       = rec[DATAWIDTH-1 -: OUT_WIDTH];
    assign rec_y       = rec[2 +: OUT_WIDTH];
    assign dec         = vec_decode(rec[1:0]);
    assign at_last     = (adrREAD == ADR_LAST);
    assign state_debug = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (draw_frame) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_WAIT_RD;
            S_WAIT_RD: if (lat_cnt == 2'd1) state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec)
                    DEC_END:  state_nxt = S_REARM;
                    DEC_LINE: state_nxt = S_ISSUE;
                    default:  state_nxt = at_last ? S_REARM : S_FETCH;
                endcase
            end
            S_ISSUE:   if (line_ready) state_nxt = at_last ? S_REARM : S_FETCH;
            // Writer keeps draw_frame high one cycle past frame_done; wait it out.
            S_REARM:   if (!draw_frame) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adrREAD    <= '0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            line_valid <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            lat_cnt    <= '0;
            rec        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (draw_frame) begin
                        adrREAD <= '0;
                        cx      <= '0;
                        cy      <= '0;
                        overrun <= 1'b0;
                    end
                end
                S_FETCH: lat_cnt <= 2'(RD_LATENCY);
                S_WAIT_RD: begin
                    lat_cnt <= lat_cnt - 2'd1;
                    if (lat_cnt == 2'd1) rec <= dataREAD;
                end
                S_DECODE: begin
                    case (dec)
                        DEC_END: frame_done <= 1'b1;
                        DEC_LINE: begin
                            x0         <= cx;
                            y0         <= cy;
                            x1         <= rec_x;
                            y1         <= rec_y;
                            line_valid <= 1'b1;
                        end
                        default: begin
                            if (dec == DEC_MOVE) begin
                                cx <= rec_x;
                                cy <= rec_y;
                            end
                            // Last address without a terminator: end the frame, never wrap.
                            if (at_last) begin
                                overrun    <= 1'b1;
                                frame_done <= 1'b1;
                            end else begin
                                adrREAD <= adrREAD + ADR_ONE;
                            end
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (line_ready) begin
                        line_valid <= 1'b0;
                        cx         <= x1;
                        cy         <= y1;
                        if (at_last) begin
                            overrun    <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            adrREAD <= adrREAD + ADR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_list_reader.sv
// Randomized scoreboard bench for vector_list_reader: a list-level model predicts the
// segments of each frame; a monitor pops and compares them as the DUT transfers them.
module tb_vector_list_reader;
    import vector_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        draw_a, fd_a, lv_a, lr_a, ov_a;
    logic [15:0] adr_a;
    logic [17:0] data_a;
    logic [7:0]  x0a, y0a, x1a, y1a;
    logic [2:0]  sd_a;

    logic        draw_b, fd_b, lv_b, lr_b, ov_b;
    logic [3:0]  adr_b;
    logic [17:0] data_b;
    logic [7:0]  x0b, y0b, x1b, y1b;
    logic [2:0]  sd_b;

    vector_list_reader dut_a (
        .clk(clk), .rst(rst), .draw_frame(draw_a), .frame_done(fd_a), .adrREAD(adr_a),
        .dataREAD(data_a), .x0(x0a), .y0(y0a), .x1(x1a), .y1(y1a), .line_valid(lv_a),
        .line_ready(lr_a), .overrun(ov_a), .state_debug(sd_a)
    );

    vector_list_reader #(.ADR_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .draw_frame(draw_b), .frame_done(fd_b), .adrREAD(adr_b),
        .dataREAD(data_b), .x0(x0b), .y0(y0b), .x1(x1b), .y1(y1b), .line_valid(lv_b),
        .line_ready(lr_b), .overrun(ov_b), .state_debug(sd_b)
    );

    logic [17:0] ram_a [0:255];
    logic [17:0] ram_b [0:15];

    always @(posedge clk) begin
        data_a <= (adr_a < 16'd256) ? ram_a[adr_a[7:0]] : 18'h0;
        data_b <= ram_b[adr_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] mk(input int x, input int y, input logic [1:0] lp);
        vec_rec_t r;
        r.x = 8'(x);
        r.y = 8'(y);
        {r.line, r.pos} = lp;
        return r;
    endfunction

    // Reference: walk the list as a pen plotter would, collecting every drawn segment.
    logic [31:0] exp_q[$];
    logic        exp_ov;

    task automatic model_a();
        logic [7:0]  pen_x, pen_y;
        logic [17:0] r;
        bit          done;
        pen_x = 0; pen_y = 0; done = 0;
        exp_q.delete();
        exp_ov = 1'b0;
        for (int i = 0; i < 256 && !done; i++) begin
            r = ram_a[i];
            if (r == REC_END) done = 1;
            else if (r[1:0] == 2'b01) {pen_x, pen_y} = {r[17:10], r[9:2]};
            else if (r[1:0] == 2'b10) begin
                exp_q.push_back({pen_x, pen_y, r[17:10], r[9:2]});
                {pen_x, pen_y} = {r[17:10], r[9:2]};
            end else if (r[1:0] == 2'b11) done = 1;
        end
    endtask

    // Drawer model: 0 always ready, 1 five-cycle stall per segment, 2 random, 3 never.
    int ready_mode = 0;
    int stall = 0;
    initial lr_a = 1'b1;
    always @(posedge clk) begin
        #1;
        if (lv_a) begin
            case (ready_mode)
                0: lr_a = 1'b1;
                1: begin lr_a = (stall == 5); stall = (stall == 5) ? 0 : stall + 1; end
                2: lr_a = 1'($urandom_range(0, 1));
                default: lr_a = 1'b0;
            endcase
        end else begin
            lr_a  = (ready_mode == 0);
            stall = 0;
        end
    end

    int          xfers_a = 0, frames_a = 0, since_rise = 0;
    bit          holding = 0, fd_prev = 0, lv_prev = 0, draw_prev = 0, lat_en = 0;
    logic [31:0] held, seg;

    always @(negedge clk) begin
        if (rst) begin
            holding = 0;
        end else begin
            since_rise = (draw_a && !draw_prev) ? 0 : since_rise + 1;
            if (lv_a && !lv_prev && lat_en) begin
                chk("first_valid_latency", since_rise, 4);
                lat_en = 0;
            end
            if (lv_a) begin
                seg = {x0a, y0a, x1a, y1a};
                if (holding) chk("segment_hold_stable", seg, held);
                if (lr_a) begin
                    xfers_a++;
                    holding = 0;
                    if (exp_q.size() == 0) chk("segment_expected", seg, 32'hffffffff);
                    else chk("segment", seg, exp_q.pop_front());
                end else begin
                    holding = 1;
                    held = seg;
                end
            end else begin
                holding = 0;
            end
            if (fd_a) begin
                frames_a++;
                chk("frame_done_width", 32'(fd_prev), 0);
                chk("overrun_at_done", 32'(ov_a), 32'(exp_ov));
                chk("queue_drained_at_done", exp_q.size(), 0);
            end
        end
        fd_prev   = fd_a;
        lv_prev   = lv_a;
        draw_prev = draw_a;
    end

    task automatic run_frame(input int mode, input int hold);
        int f0, x_start, nseg, c;
        ready_mode = mode;
        model_a();
        f0 = frames_a; x_start = xfers_a; nseg = exp_q.size();
        @(posedge clk); #1 draw_a = 1'b1;
        for (c = 0; c < 10 && sd_a != 3'd1; c++) @(negedge clk);
        chk("fetch_state_reached", 32'(sd_a), 1);
        chk("restart_adr0", 32'(adr_a), 0);
        for (c = 0; c < 5000 && frames_a == f0; c++) @(negedge clk);
        chk("frame_done_seen", frames_a - f0, 1);
        repeat (hold) @(posedge clk);
        #1 draw_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_after_frame", 32'(sd_a), 0);
        chk("transfer_count", xfers_a - x_start, nseg);
        chk("no_second_walk", frames_a - f0, 1);
        chk("overrun_clear", 32'(ov_a), 0);
    endtask

    task automatic random_list();
        int n, k;
        n = $urandom_range(1, 40);
        for (int i = 0; i < 256; i++) ram_a[i] = 18'($urandom);
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 9);
            ram_a[i] = mk($urandom_range(0, 255), $urandom_range(0, 255),
                          (k < 3) ? 2'b01 : (k < 8) ? 2'b10 : 2'b00);
        end
        ram_a[n] = REC_END;
    endtask

    initial begin
        int  c;
        bit  wrapped;
        logic [3:0] prev;
        rst = 1'b1; draw_a = 1'b0; draw_b = 1'b0; lr_b = 1'b1;
        for (int i = 0; i < 256; i++) ram_a[i] = REC_END;
        for (int i = 0; i < 16; i++) ram_b[i] = REC_END;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(sd_a), 0);
        chk("reset_outputs", {x0a, y0a, x1a, y1a}, 0);
        chk("reset_ctrl", {adr_a, 13'd0, lv_a, fd_a, ov_a}, 0);
        @(posedge clk); #1 rst = 1'b0;

        ram_a[0] = mk(10, 20, 2'b01);
        ram_a[1] = mk(50, 20, 2'b10);
        ram_a[2] = mk(50, 60, 2'b10);
        ram_a[3] = REC_END;
        run_frame(0, 1);
        run_frame(1, 1);
        run_frame(0, 3);

        for (int f = 0; f < 6; f++) begin
            random_list();
            run_frame(2, $urandom_range(1, 3));
        end

        ram_a[0] = mk(30, 40, 2'b10);
        ram_a[1] = mk(7, 9, 2'b00);
        ram_a[2] = REC_END;
        lat_en = 1;
        run_frame(0, 1);
        chk("latency_check_ran", 32'(lat_en), 0);

        for (int i = 0; i < 16; i++)
            ram_b[i] = mk($urandom_range(0, 255), $urandom_range(0, 255), 2'($urandom_range(0, 2)));
        @(posedge clk); #1 draw_b = 1'b1;
        wrapped = 0; prev = 0;
        for (c = 0; c < 300 && !fd_b; c++) begin
            @(negedge clk);
            if (adr_b < prev) wrapped = 1;
            prev = adr_b;
        end
        chk("b_frame_done_seen", 32'(fd_b), 1);
        chk("b_adr_at_last", 32'(adr_b), 15);
        chk("b_overrun_set", 32'(ov_b), 1);
        @(posedge clk); #1 draw_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_no_wrap", 32'(wrapped) | 32'(adr_b != 4'd15), 0);
        chk("b_idle", 32'(sd_b), 0);
        chk("b_overrun_sticky", 32'(ov_b), 1);
        ram_b[3] = REC_END;
        @(posedge clk); #1 draw_b = 1'b1;
        for (c = 0; c < 300 && !fd_b; c++) @(negedge clk);
        chk("b_second_done", 32'(fd_b), 1);
        chk("b_overrun_cleared", 32'(ov_b), 0);
        chk("b_end_adr", 32'(adr_b), 3);
        @(posedge clk); #1 draw_b = 1'b0;

        ram_a[0] = mk(30, 40, 2'b10);
        ram_a[1] = REC_END;
        ready_mode = 3;
        model_a();
        @(posedge clk); #1 draw_a = 1'b1;
        for (c = 0; c < 20 && !lv_a; c++) @(negedge clk);
        chk("rst_test_in_issue", 32'(sd_a), 4);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid_drop", 32'(lv_a), 0);
        chk("rst_coords", {x0a, y0a, x1a, y1a}, 0);
        chk("rst_ctrl", {adr_a, 13'd0, sd_a}, 0);
        chk("rst_flags", {fd_a, ov_a}, 0);
        exp_q.delete();
        @(posedge clk); #1 draw_a = 1'b0; ready_mode = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", 32'(sd_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
